// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned BLOCK_W  = 128;

    typedef enum logic [1:0] {
        StIdle,
        StMissRead,
        StUpdate
    } icache_state_e;

    function automatic int unsigned idx_width(input int unsigned lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    function automatic int unsigned tag_width(input int unsigned lines);
        return ADDR_W - OFFSET_W - idx_width(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one write port, one combinational read port, flush-all.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = 25,
    parameter int unsigned IDX_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [BLOCK_W-1:0] rdata_o
);

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    // Valid bits: flush clears all, but a same-edge install wins for its own line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end
            if (we_i) begin
                valid_q[waddr_i] <= 1'b1;
            end
        end
    end

    // Tag and data contents need no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[raddr_i];
    assign rtag_o   = tag_q[raddr_i];
    assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller with block refill FSM.
// Optional hit/miss counters enabled by defining ICACHE_PERF_CNT_EN.
module icache_controller
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = tag_width(LINES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                READ,
    input  logic [ADDR_W-1:0]   ADDRESS,
    input  logic                FLUSH,
    output logic [WORD_W-1:0]   INSTRUCTION,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic [27:0]         MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]  MEM_READDATA,
    input  logic                MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]         HIT_COUNT,
    output logic [31:0]         MISS_COUNT
`endif
);

    localparam int unsigned IDX_W      = idx_width(LINES);
    localparam int unsigned BLK_ADDR_W = ADDR_W - OFFSET_W;

    icache_state_e         state_q, state_d;
    logic [BLK_ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [BLOCK_W-1:0]    fill_data_q, fill_data_d;

    logic [IDX_W-1:0]   rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic [1:0]         word_sel;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               line_we;
    logic               busy_raw;

    assign rd_idx   = ADDRESS[OFFSET_W +: IDX_W];
    assign rd_tag   = ADDRESS[ADDR_W-1 -: TAG_W];
    assign word_sel = ADDRESS[3:2];

    icache_line_store #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_line_store (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .flush_i  (FLUSH),
        .we_i     (line_we),
        .waddr_i  (miss_addr_q[IDX_W-1:0]),
        .wtag_i   (miss_addr_q[BLK_ADDR_W-1 -: TAG_W]),
        .wdata_i  (fill_data_q),
        .raddr_i  (rd_idx),
        .rvalid_o (line_valid),
        .rtag_o   (line_tag),
        .rdata_o  (line_data)
    );

    assign hit         = READ & line_valid & (line_tag == rd_tag);
    assign INSTRUCTION = hit ? line_data[{word_sel, 5'd0} +: WORD_W] : '0;
    // Stall is forced low while reset is held, even though valid bits read as zero.
    assign BUSYWAIT    = RESET & busy_raw;
    // Refill address is the latched miss block; it simply holds while idle.
    assign MEM_ADDRESS = miss_addr_q;

    // Refill FSM: next state, miss latch and handshake outputs.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_data_d = fill_data_q;
        busy_raw    = 1'b0;
        MEM_READ    = 1'b0;
        line_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_raw = READ & ~hit;
                if (READ && !hit) begin
                    miss_addr_d = ADDRESS[ADDR_W-1:OFFSET_W];
                    state_d     = StMissRead;
                end
            end
            StMissRead: begin
                busy_raw = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_data_d = MEM_READDATA;
                    state_d     = StUpdate;
                end
            end
            StUpdate: begin
                busy_raw = 1'b1;
                line_we  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and refill registers; reset abandons any refill in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Count idle-state hits and miss launches; both wrap naturally.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StIdle && READ) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: doc/icache_controller.md
# icache_controller

Direct-mapped instruction cache controller between the CPU fetch stage and the 128-bit-block instruction memory. It serves 32-bit instruction fetches from an internal 8-line × 128-bit store. On a miss it sequences a block read from instruction memory using that memory's READ/BUSYWAIT handshake, installs the block, then completes the fetch.

## Interface
Parameters:
- LINES, 8: number of cache lines; power of two; index width is log2(LINES).
- TAG_W, 25: tag width, equal to 28 − log2(LINES).

Ports (clock/reset: one clock; reset is asynchronous and active-low):
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous active-low reset.
- READ  input  1  CPU fetch request.
- ADDRESS  input  32  CPU byte address; [3:2] word, [6:4] index, [31:7] tag.
- FLUSH  input  1  invalidate all lines, sampled at the clock edge.
- INSTRUCTION  output  32  fetched instruction word.
- BUSYWAIT  output  1  CPU stall request.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address (byte address [31:4]).
- MEM_READDATA  input  128  block from memory; byte 0 is in [7:0].
- MEM_BUSYWAIT  input  1  memory busy; a low level while MEM_READ is high means the data is valid.

## Operation
- Storage per line: valid bit, TAG_W tag, 128-bit data. Word n of the block is data[32n+31:32n].
- hit = READ & valid[index] & (tag[index] == ADDRESS[31:7]).
- INSTRUCTION = selected word when hit, else 32'h0. This path is combinational.
- BUSYWAIT = READ & !hit in IDLE. It is 1 in MISS_READ and UPDATE, and 0 while RESET is low.
- FSM states:
  - IDLE: on a clock edge with READ & !hit, latch ADDRESS[31:4] into miss_addr and go to MISS_READ.
  - MISS_READ: MEM_READ=1 and MEM_ADDRESS=miss_addr. When MEM_BUSYWAIT is sampled 0 at a clock edge, capture MEM_READDATA and go to UPDATE.
  - UPDATE: MEM_READ=0. Write data, tag and valid=1 into the line at miss_addr index, then go to IDLE.
- In IDLE, MEM_READ=0 and MEM_ADDRESS holds its last value.
- The refill uses the latched miss_addr. If ADDRESS changes mid-miss, the old block is still installed, and the new address is re-evaluated in IDLE.
- READ dropping mid-miss does not abort the refill.
- FLUSH clears all valid bits at the clock edge in any state. If FLUSH coincides with the UPDATE write, the line being written ends up valid; other lines are cleared.
- Reset: all valid bits=0, state=IDLE, MEM_READ=0, MEM_ADDRESS=0, miss_addr=0, counters=0. Tag and data contents are don't-care.
- Reset mid-refill abandons the refill immediately. The memory sees MEM_READ fall.

## Timing
- Hit: zero cycles. INSTRUCTION is valid and BUSYWAIT low in the same cycle READ/ADDRESS are presented.
- Miss sequence:
  - Edge 0: IDLE→MISS_READ; MEM_READ rises after edge 0.
  - Edge k: the first edge with MEM_BUSYWAIT=0 → UPDATE.
  - Edge k+1: line written → IDLE; the fetch hits and BUSYWAIT falls.
- Miss penalty = memory latency + 2 cycles.
- MEM_READ is held high, and MEM_ADDRESS held stable, for the whole of MISS_READ.

## Configuration
- ICACHE_PERF_CNT_EN defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments on each edge in IDLE with READ & hit.
  - MISS_COUNT increments on each IDLE→MISS_READ transition.
  - Both wrap from 32'hFFFFFFFF to 0, and both reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package icache_pkg holds:
  - the state enum (IDLE, MISS_READ, UPDATE);
  - constants OFFSET_W=4 and BLOCK_W=128;
  - index/tag width derivation.
- Sub-module icache_line_store holds the valid/tag/data arrays: one write port, one combinational read port, flush-all input, async reset of valid bits. The FSM, hit compare and word select stay in icache_controller.

## Test plan
- Cold miss: reset, READ=1, ADDRESS=32'h0000_0004 → BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=28'h0. The memory returns block 128'h…_0000000F_00000001_… → after UPDATE, INSTRUCTION = word 1 and BUSYWAIT=0 the next cycle.
- Hit path: after the cold miss, ADDRESS=32'h0000_0008 → INSTRUCTION = word 2 in the same cycle, no MEM_READ, BUSYWAIT=0.
- Conflict eviction: fetch 32'h0000_0000, then 32'h0000_0080 (same index, tag 1) → second is a miss with MEM_ADDRESS=28'h8. Re-fetching 32'h0000_0000 misses again.
- Address change mid-miss: miss on 32'h10, switch ADDRESS to 32'h20 during MISS_READ → block 1 installed, then a new miss with MEM_ADDRESS=28'h2.
- Flush/reset: FLUSH=1 for one cycle → the previously hitting address misses. RESET low during MISS_READ → MEM_READ=0 and BUSYWAIT=0 immediately, and all lines are invalid afterwards.
- With ICACHE_PERF_CNT_EN: 3 distinct cold misses and 5 hit cycles → MISS_COUNT=3, HIT_COUNT=5.
